// File: rtl/frame_normalizer.sv
// frame_normalizer
//   Memory-to-memory normaliser for thermal frames. Reads DEPTH signed
//   samples, maps [min, min+range] onto 0..2^OUTW-1 using a fixed-point
//   scale produced by an internal restoring divider, and writes the pixels
//   back out with the read address carried through the pipeline.
//
//   Modes:
//     manual : min/range taken from i_min/i_range on the start cycle.
//     auto   : a scan pass over memory finds min/max first.
//
//   Ports:
//     i_clk, i_rst          clock, synchronous active-high reset
//     i_start, i_auto       frame start (IDLE only), mode select
//     i_min, i_range        manual min (signed) and range (unsigned)
//     o_busy, o_done        busy level, one-cycle completion pulse
//     o_min, o_range        min and raw range used for the frame
//     o_rd_valid/o_rd_addr  read request; i_rd_data returns one cycle later
//     o_wr_valid/o_wr_addr/o_wr_data  normalised pixel write
//
//   Build option:
//     NORM_INVERT_EN  when defined, writes (2^OUTW-1)-q (cold maps to bright).
module frame_normalizer #(
  parameter int DATAW = 16,
  parameter int DEPTH = 64,
  parameter int OUTW  = 8,
  parameter int FRACW = 12,
  parameter int ADDRW = $clog2(DEPTH),
  parameter int SCW   = OUTW + FRACW
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_auto,
  input  logic [DATAW-1:0] i_min,
  input  logic [DATAW-1:0] i_range,
  output logic             o_busy,
  output logic             o_done,
  output logic [DATAW-1:0] o_min,
  output logic [DATAW-1:0] o_range,
  output logic             o_rd_valid,
  output logic [ADDRW-1:0] o_rd_addr,
  input  logic [DATAW-1:0] i_rd_data,
  output logic             o_wr_valid,
  output logic [ADDRW-1:0] o_wr_addr,
  output logic [OUTW-1:0]  o_wr_data
);

  // Width of prod >> FRACW, and of the full product
  localparam int HIW   = DATAW + OUTW;
  localparam int PRODW = HIW + FRACW;
  localparam int CNTW  = $clog2(SCW);

  localparam logic [SCW-1:0]   DIVIDEND  = {{OUTW{1'b1}}, {FRACW{1'b0}}};
  localparam logic [OUTW-1:0]  PIX_MAX   = {OUTW{1'b1}};
  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(DEPTH - 1);
  localparam logic [DATAW-1:0] ONE       = DATAW'(1);
  localparam logic [CNTW-1:0]  DIV_LAST  = CNTW'(SCW - 1);

  typedef enum logic [2:0] {IDLE, SCAN, DIVIDE, NORM, DONE} state_t;

  state_t                  state_reg;
  logic                    rd_valid_reg;
  logic [ADDRW-1:0]        rd_addr_reg;
  logic [DATAW-1:0]        min_reg;
  logic [DATAW-1:0]        range_reg;
  logic signed [DATAW-1:0] scan_min_reg;
  logic signed [DATAW-1:0] scan_max_reg;
  logic [DATAW-1:0]        rem_reg;
  logic [SCW-1:0]          quo_reg;
  logic [CNTW-1:0]         div_cnt_reg;
  logic [SCW-1:0]          scale_reg;
  logic                    done_reg;

  // Pipeline: pend = read data arriving, s1 = clamped delta, s2 = scaled value
  logic                    pend_valid_reg;
  logic [ADDRW-1:0]        pend_addr_reg;
  logic                    s1_valid_reg;
  logic [ADDRW-1:0]        s1_addr_reg;
  logic [DATAW-1:0]        s1_delta_reg;
  logic                    s2_valid_reg;
  logic [ADDRW-1:0]        s2_addr_reg;
  logic [HIW-1:0]          s2_hi_reg;

  // A zero range would divide by zero; treat it as 1
  logic [DATAW-1:0] range_eff;
  assign range_eff = (range_reg == '0) ? ONE : range_reg;

  // Scan fold: the sample at address 0 seeds both extremes
  logic signed [DATAW-1:0] sample;
  logic signed [DATAW-1:0] fold_min;
  logic signed [DATAW-1:0] fold_max;
  logic [DATAW-1:0]        scan_range;

  assign sample = i_rd_data;

  always_comb begin
    fold_min = scan_min_reg;
    fold_max = scan_max_reg;
    if (pend_addr_reg == '0) begin
      fold_min = sample;
      fold_max = sample;
    end else begin
      if (sample < scan_min_reg) fold_min = sample;
      if (sample > scan_max_reg) fold_max = sample;
    end
  end

  assign scan_range = fold_max - fold_min;

  // Restoring divider step: the dividend is shifted out of quo_reg MSB-first
  // while quotient bits shift in at the bottom.
  logic [DATAW:0]   rem_shift;
  logic             div_take;
  logic [DATAW-1:0] rem_next;
  logic [SCW-1:0]   quo_next;

  always_comb begin
    rem_shift = {rem_reg, quo_reg[SCW-1]};
    div_take  = (rem_shift >= {1'b0, range_eff});
    rem_next  = div_take ? DATAW'(rem_shift - {1'b0, range_eff}) : rem_shift[DATAW-1:0];
    quo_next  = {quo_reg[SCW-2:0], div_take};
  end

  // Stage 1: signed difference at DATAW+1 bits, clamped into [0, range_eff]
  logic [DATAW:0]   diff;
  logic [DATAW-1:0] delta_clamped;

  always_comb begin
    diff = {i_rd_data[DATAW-1], i_rd_data} - {min_reg[DATAW-1], min_reg};
    if (diff[DATAW]) begin
      delta_clamped = '0;
    end else if (diff[DATAW-1:0] > range_eff) begin
      delta_clamped = range_eff;
    end else begin
      delta_clamped = diff[DATAW-1:0];
    end
  end

  // Stage 2: scale and drop the fractional bits
  logic [HIW-1:0] prod_hi;
  assign prod_hi = HIW'((PRODW'(s1_delta_reg) * PRODW'(scale_reg)) >> FRACW);

  // Output stage: saturate, then optionally invert
  logic            sat;
  logic [OUTW-1:0] q;
  logic [OUTW-1:0] pix;

  assign sat = |s2_hi_reg[HIW-1:OUTW];
  assign q   = sat ? PIX_MAX : s2_hi_reg[OUTW-1:0];

`ifdef NORM_INVERT_EN
  assign pix = PIX_MAX - q;
`else
  assign pix = q;
`endif

  // Control FSM
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= IDLE;
      rd_valid_reg <= 1'b0;
      rd_addr_reg  <= '0;
      min_reg      <= '0;
      range_reg    <= '0;
      scan_min_reg <= '0;
      scan_max_reg <= '0;
      rem_reg      <= '0;
      quo_reg      <= '0;
      div_cnt_reg  <= '0;
      scale_reg    <= '0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;

      // Read sequencer shared by SCAN and NORM: 0..DEPTH-1, no gaps, no wrap
      if (rd_valid_reg) begin
        if (rd_addr_reg == LAST_ADDR) begin
          rd_valid_reg <= 1'b0;
          rd_addr_reg  <= '0;
        end else begin
          rd_addr_reg <= rd_addr_reg + 1'b1;
        end
      end

      unique case (state_reg)
        IDLE: begin
          if (i_start) begin
            if (i_auto) begin
              state_reg    <= SCAN;
              rd_valid_reg <= 1'b1;
              rd_addr_reg  <= '0;
            end else begin
              state_reg   <= DIVIDE;
              min_reg     <= i_min;
              range_reg   <= i_range;
              rem_reg     <= '0;
              quo_reg     <= DIVIDEND;
              div_cnt_reg <= '0;
            end
          end
        end

        SCAN: begin
          if (pend_valid_reg) begin
            scan_min_reg <= fold_min;
            scan_max_reg <= fold_max;
            if (pend_addr_reg == LAST_ADDR) begin
              state_reg   <= DIVIDE;
              min_reg     <= fold_min;
              range_reg   <= scan_range;
              rem_reg     <= '0;
              quo_reg     <= DIVIDEND;
              div_cnt_reg <= '0;
            end
          end
        end

        DIVIDE: begin
          rem_reg     <= rem_next;
          quo_reg     <= quo_next;
          div_cnt_reg <= div_cnt_reg + 1'b1;
          if (div_cnt_reg == DIV_LAST) begin
            state_reg    <= NORM;
            scale_reg    <= quo_next;
            rd_valid_reg <= 1'b1;
            rd_addr_reg  <= '0;
          end
        end

        NORM: begin
          // Leave once the final pixel is on the write port
          if (s2_valid_reg && (s2_addr_reg == LAST_ADDR)) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end

        DONE: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Normalisation pipeline; only NORM-pass reads enter stage 1
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend_valid_reg <= 1'b0;
      pend_addr_reg  <= '0;
      s1_valid_reg   <= 1'b0;
      s1_addr_reg    <= '0;
      s1_delta_reg   <= '0;
      s2_valid_reg   <= 1'b0;
      s2_addr_reg    <= '0;
      s2_hi_reg      <= '0;
    end else begin
      pend_valid_reg <= rd_valid_reg;
      pend_addr_reg  <= rd_addr_reg;
      s1_valid_reg   <= pend_valid_reg && (state_reg == NORM);
      s1_addr_reg    <= pend_addr_reg;
      s1_delta_reg   <= delta_clamped;
      s2_valid_reg   <= s1_valid_reg;
      s2_addr_reg    <= s1_addr_reg;
      s2_hi_reg      <= prod_hi;
    end
  end

  assign o_busy     = (state_reg != IDLE);
  assign o_done     = done_reg;
  assign o_min      = min_reg;
  assign o_range    = range_reg;
  assign o_rd_valid = rd_valid_reg;
  assign o_rd_addr  = rd_addr_reg;
  assign o_wr_valid = s2_valid_reg;
  assign o_wr_addr  = s2_addr_reg;
  assign o_wr_data  = s2_valid_reg ? pix : '0;

endmodule

// File: tb/tb_frame_normalizer.sv
// Testbench for frame_normalizer: behavioural memory, write monitor,
// table of expected pixels per scenario, plus hand-written control sequences.
module tb_frame_normalizer;
  localparam int DATAW = 16;
  localparam int DEPTH = 64;
  localparam int OUTW  = 8;
  localparam int ADDRW = 6;
  localparam int NV    = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             auto_m;
  logic [DATAW-1:0] min_v;
  logic [DATAW-1:0] range_v;
  logic             busy;
  logic             done;
  logic [DATAW-1:0] omin;
  logic [DATAW-1:0] orange;
  logic             rd_valid;
  logic [ADDRW-1:0] rd_addr;
  logic [DATAW-1:0] rd_data;
  logic             wr_valid;
  logic [ADDRW-1:0] wr_addr;
  logic [OUTW-1:0]  wr_data;

  always #5 clk = ~clk;

  frame_normalizer dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_auto     (auto_m),
    .i_min      (min_v),
    .i_range    (range_v),
    .o_busy     (busy),
    .o_done     (done),
    .o_min      (omin),
    .o_range    (orange),
    .o_rd_valid (rd_valid),
    .o_rd_addr  (rd_addr),
    .i_rd_data  (rd_data),
    .o_wr_valid (wr_valid),
    .o_wr_addr  (wr_addr),
    .o_wr_data  (wr_data)
  );

  // Frame memory with one-cycle read latency
  logic [DATAW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (rd_valid) rd_data <= mem[rd_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record every read/write/done with its cycle number
  int wr_total = 0;
  int done_total = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;
  int wr_q [DEPTH];
  int wr_cyc [DEPTH];
  int rd_cyc [DEPTH];
  always @(negedge clk) begin
    if (rd_valid) rd_cyc[rd_addr] = cyc;
    if (wr_valid) begin
      wr_q[wr_addr]   = int'(wr_data);
      wr_cyc[wr_addr] = cyc;
      last_wr_cyc     = cyc;
      wr_total++;
    end
    if (done) begin
      done_cyc = cyc;
      done_total++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int exp_px(input int q);
`ifdef NORM_INVERT_EN
    return 255 - q;
`else
    return q;
`endif
  endfunction

  typedef struct {
    int scen;
    int addr;
    int q;
  } wvec_t;

  wvec_t tbl [NV];

  task automatic check_table(input int scen, input string tag);
    for (int k = 0; k < NV; k++) begin
      if (tbl[k].scen == scen)
        check($sformatf("%s addr%0d", tag, tbl[k].addr), wr_q[tbl[k].addr], exp_px(tbl[k].q));
    end
  endtask

  task automatic wait_done(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check($sformatf("%s done_timeout", tag), int'(got), 1);
  endtask

  // Called at a negedge with the DUT idle
  task automatic run_frame(input bit a, input int mn, input int rg, input string tag);
    int base_w;
    int base_d;
    base_w  = wr_total;
    base_d  = done_total;
    start   = 1'b1;
    auto_m  = a;
    min_v   = 16'(mn);
    range_v = 16'(rg);
    @(negedge clk);
    // Scramble the inputs: they must have been latched on the start cycle
    start   = 1'b0;
    auto_m  = ~a;
    min_v   = 16'h1234;
    range_v = 16'h0007;
    wait_done(tag);
    repeat (2) @(negedge clk);
    check($sformatf("%s write_count", tag), wr_total - base_w, 64);
    check($sformatf("%s done_pulses", tag), done_total - base_d, 1);
    check($sformatf("%s done_after_last_write", tag), done_cyc - last_wr_cyc, 1);
    check($sformatf("%s write_span", tag), wr_cyc[DEPTH-1] - wr_cyc[0], DEPTH - 1);
    for (int i = 0; i < DEPTH; i++)
      check($sformatf("%s latency addr%0d", tag, i), wr_cyc[i] - rd_cyc[i], 3);
    check($sformatf("%s busy_after", tag), int'(busy), 0);
    $display("frame %s: min=%0d range=%0d writes=%0d", tag, $signed(omin), orange, wr_total - base_w);
  endtask

  int  base_w;
  int  base_d;
  bit  got;

  initial begin
    tbl[0]  = '{1, 0, 0};
    tbl[1]  = '{1, 1, 127};
    tbl[2]  = '{1, 2, 254};
    tbl[3]  = '{1, 10, 0};
    tbl[4]  = '{2, 0, 0};
    tbl[5]  = '{2, 63, 254};
    tbl[6]  = '{2, 32, 129};
    tbl[7]  = '{2, 1, 4};
    tbl[8]  = '{3, 0, 0};
    tbl[9]  = '{3, 1, 254};
    tbl[10] = '{3, 2, 127};
    tbl[11] = '{3, 3, 0};
    tbl[12] = '{3, 4, 254};
    tbl[13] = '{4, 0, 0};
    tbl[14] = '{4, 63, 0};

    rst = 1'b1; start = 1'b0; auto_m = 1'b0; min_v = '0; range_v = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset rd_valid", int'(rd_valid), 0);
    check("reset wr_valid", int'(wr_valid), 0);
    check("reset wr_data", int'(wr_data), 0);
    check("reset min", int'(omin), 0);
    check("reset range", int'(orange), 0);
    rst = 1'b0;
    @(negedge clk);

    // Scenario 1: manual min=100 range=1000
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'd100;
    mem[1] = 16'd600;
    mem[2] = 16'd1100;
    run_frame(1'b0, 100, 1000, "manual");
    check("manual min", $signed(omin), 100);
    check("manual range", int'(orange), 1000);
    check_table(1, "manual");

    // Scenario 2: auto, mem[a] = a-50
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'(i - 50);
    run_frame(1'b1, 0, 0, "auto");
    check("auto min", $signed(omin), -50);
    check("auto range", int'(orange), 63);
    check_table(2, "auto");

    // Scenario 3: clipping, manual min=0 range=100
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    mem[0] = 16'hFFFB;
    mem[1] = 16'd300;
    mem[2] = 16'd50;
    mem[3] = 16'h8000;
    mem[4] = 16'h7FFF;
    run_frame(1'b0, 0, 100, "clip");
    check_table(3, "clip");

    // Scenario 4: constant frame in auto mode
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'd500;
    run_frame(1'b1, 0, 0, "const");
    check("const min", $signed(omin), 500);
    check("const range", int'(orange), 0);
    check_table(4, "const");
    for (int i = 0; i < DEPTH; i++)
      check($sformatf("const all addr%0d", i), wr_q[i], exp_px(0));

    // Scenario 5: start pulsed during NORM is ignored
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'd100;
    mem[1] = 16'd600;
    mem[2] = 16'd1100;
    base_w = wr_total;
    base_d = done_total;
    start = 1'b1; auto_m = 1'b0; min_v = 16'd100; range_v = 16'd1000;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      if (wr_valid) got = 1'b1;
    end
    check("ignore reach_norm", int'(got), 1);
    start = 1'b1; auto_m = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore");
    repeat (40) @(negedge clk);
    check("ignore write_count", wr_total - base_w, 64);
    check("ignore done_pulses", done_total - base_d, 1);
    check("ignore busy_after", int'(busy), 0);
    check_table(1, "ignore");
    $display("frame ignore: writes=%0d", wr_total - base_w);

    // Scenario 6: reset mid-NORM
    base_w = wr_total;
    start = 1'b1; auto_m = 1'b0; min_v = 16'd100; range_v = 16'd1000;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      if (wr_total - base_w >= 5) got = 1'b1;
    end
    check("midrst reach_norm", int'(got), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst busy", int'(busy), 0);
    check("midrst wr_valid", int'(wr_valid), 0);
    check("midrst rd_valid", int'(rd_valid), 0);
    check("midrst done", int'(done), 0);
    check("midrst min", int'(omin), 0);
    rst = 1'b0;
    base_w = wr_total;
    repeat (10) @(negedge clk);
    check("midrst stray_writes", wr_total - base_w, 0);
    $display("frame midrst: reset applied during NORM");
    run_frame(1'b0, 100, 1000, "after_rst");
    check_table(1, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
